// File: rtl/fetch_prefetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_prefetch_queue
//  Function : Instruction-fetch front end. It issues sequential word fetches
//             over req/ack and buffers {pc, instr} pairs for the core.
//             It also flushes the buffer on branch/jump redirects.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_out_valid,
    output logic [31:0] o_out_instr,
    output logic [31:0] o_out_pc,
    input  logic        i_out_ready
);

    localparam int unsigned c_PW = $clog2(DEPTH);
    localparam int unsigned c_CW = c_PW + 1;
    localparam logic [c_CW-1:0] c_DEPTH = c_CW'(DEPTH);

    typedef enum logic [0:0] {
        S_RUN     = 1'b0,
        S_DISCARD = 1'b1
    } state_t;

    state_t            r_state, w_state_n;
    logic              r_req,   w_req_n;
    logic [31:0]       r_addr,  w_addr_n;
    logic [31:0]       r_fpc,   w_fpc_n;
    logic [c_CW-1:0]   r_count, w_count_n;
    logic [c_PW-1:0]   r_rd_ptr, r_wr_ptr;
    logic [31:0]       r_pc_mem    [DEPTH];
    logic [31:0]       r_instr_mem [DEPTH];

    logic              w_push, w_pop;
    logic [31:0]       w_rpc;

    assign w_rpc  = i_redirect_pc & ~32'h3;
    assign w_push = r_req & i_imem_ack & (r_state == S_RUN) & ~i_redirect;
    assign w_pop  = o_out_valid & i_out_ready;
    assign w_count_n = r_count + {{(c_CW-1){1'b0}}, w_push} - {{(c_CW-1){1'b0}}, w_pop};

    always_comb begin
        w_state_n = r_state;
        w_req_n   = r_req;
        w_addr_n  = r_addr;
        w_fpc_n   = r_fpc;
        if (i_redirect) begin
            if (!r_req || i_imem_ack) begin
                w_state_n = S_RUN;
                w_req_n   = 1'b1;
                w_addr_n  = w_rpc;
                w_fpc_n   = w_rpc + 32'd4;
            end else begin
                // The pending fetch cannot be cancelled; wait for it and drop its data.
                w_state_n = S_DISCARD;
                w_fpc_n   = w_rpc;
            end
        end else if (r_state == S_DISCARD) begin
            if (r_req && i_imem_ack) begin
                w_state_n = S_RUN;
                w_req_n   = 1'b1;
                w_addr_n  = r_fpc;
                w_fpc_n   = r_fpc + 32'd4;
            end
        end else if (!(r_req && !i_imem_ack)) begin
            // A new request is issued only when its FIFO slot is already guaranteed.
            if (w_count_n < c_DEPTH) begin
                w_req_n  = 1'b1;
                w_addr_n = r_fpc;
                w_fpc_n  = r_fpc + 32'd4;
            end else begin
                w_req_n  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_RUN;
            r_req    <= 1'b0;
            r_addr   <= RESET_PC;
            r_fpc    <= RESET_PC;
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            r_state <= w_state_n;
            r_req   <= w_req_n;
            r_addr  <= w_addr_n;
            r_fpc   <= w_fpc_n;
            if (i_redirect) begin
                r_count  <= '0;
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                r_count <= w_count_n;
                if (w_push) r_wr_ptr <= r_wr_ptr + c_PW'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]    <= r_addr;
            r_instr_mem[r_wr_ptr] <= i_imem_rdata;
        end
    end

    assign o_imem_req  = r_req;
    assign o_imem_addr = r_addr;
    assign o_out_valid = (r_count != '0);
    assign o_out_pc    = r_pc_mem[r_rd_ptr];
    assign o_out_instr = r_instr_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_fetch_prefetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_prefetch_queue
//  Function : Directed, table-driven bench for fetch_prefetch_queue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_prefetch_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        w_req;
    logic [31:0] w_addr;
    logic        w_ack;
    logic [31:0] w_rdata;
    logic        r_redirect;
    logic [31:0] r_redirect_pc;
    logic        w_valid;
    logic [31:0] w_instr;
    logic [31:0] w_pc;
    logic        r_ready;
    logic        r_ack_en;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] imodel(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    // Memory model: ack gated by a bench-controlled enable, data from address.
    assign w_ack   = w_req & r_ack_en;
    assign w_rdata = imodel(w_addr);

    fetch_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .o_imem_req   (w_req),
        .o_imem_addr  (w_addr),
        .i_imem_ack   (w_ack),
        .i_imem_rdata (w_rdata),
        .i_redirect   (r_redirect),
        .i_redirect_pc(r_redirect_pc),
        .o_out_valid  (w_valid),
        .o_out_instr  (w_instr),
        .o_out_pc     (w_pc),
        .i_out_ready  (r_ready)
    );

    typedef struct {
        logic        ack_en;
        logic        ready;
        logic        redir;
        logic [31:0] rpc;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t tbl [32];
    int   n_vec = 0;

    task automatic add(input logic ack_en, input logic ready, input logic redir,
                       input logic [31:0] rpc, input logic exp_req,
                       input logic [31:0] exp_addr, input logic exp_valid,
                       input logic [31:0] exp_pc);
        tbl[n_vec] = '{ack_en, ready, redir, rpc, exp_req, exp_addr, exp_valid, exp_pc};
        n_vec++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic req, input logic [31:0] addr,
                             input logic valid, input logic [31:0] pc);
        chk({tag, " req"},   {31'd0, w_req},   {31'd0, req});
        chk({tag, " addr"},  w_addr,           addr);
        chk({tag, " valid"}, {31'd0, w_valid}, {31'd0, valid});
        if (valid) begin
            chk({tag, " pc"},    w_pc,    pc);
            chk({tag, " instr"}, w_instr, imodel(pc));
        end
    endtask

    initial begin
        rst_n = 1'b0; r_ack_en = 1'b0; r_ready = 1'b0;
        r_redirect = 1'b0; r_redirect_pc = 32'h0;

        //  ack ready redir rpc            | req addr          valid pc
        add(1, 1, 0, 32'h0,          0, 32'h0,          0, 32'h0);
        add(1, 1, 0, 32'h0,          1, 32'h0,          0, 32'h0);
        add(1, 1, 0, 32'h0,          1, 32'h4,          1, 32'h0);
        add(1, 0, 0, 32'h0,          1, 32'h8,          1, 32'h4);
        add(1, 0, 0, 32'h0,          1, 32'hC,          1, 32'h4);
        add(1, 0, 0, 32'h0,          1, 32'h10,         1, 32'h4);
        add(1, 0, 0, 32'h0,          0, 32'h10,         1, 32'h4);
        add(1, 1, 0, 32'h0,          0, 32'h10,         1, 32'h4);
        add(1, 1, 0, 32'h0,          1, 32'h14,         1, 32'h8);
        add(0, 1, 0, 32'h0,          1, 32'h18,         1, 32'hC);
        add(0, 0, 1, 32'h103,        1, 32'h18,         1, 32'h10);
        add(0, 1, 0, 32'h0,          1, 32'h18,         0, 32'h0);
        add(1, 1, 0, 32'h0,          1, 32'h18,         0, 32'h0);
        add(1, 1, 0, 32'h0,          1, 32'h100,        0, 32'h0);
        add(1, 1, 1, 32'h200,        1, 32'h104,        1, 32'h100);
        add(1, 1, 0, 32'h0,          1, 32'h200,        0, 32'h0);
        add(0, 0, 1, 32'h300,        1, 32'h204,        1, 32'h200);
        add(1, 1, 1, 32'h400,        1, 32'h204,        0, 32'h0);
        add(1, 1, 0, 32'h0,          1, 32'h400,        0, 32'h0);
        add(0, 1, 0, 32'h0,          1, 32'h404,        1, 32'h400);
        add(1, 1, 1, 32'hFFFF_FFFC,  1, 32'h404,        0, 32'h0);
        add(1, 1, 0, 32'h0,          1, 32'hFFFF_FFFC,  0, 32'h0);
        add(1, 1, 0, 32'h0,          1, 32'h0,          1, 32'hFFFF_FFFC);
        add(0, 0, 1, 32'h500,        1, 32'h4,          1, 32'h0);
        add(0, 0, 0, 32'h0,          1, 32'h4,          0, 32'h0);

        repeat (2) @(posedge clk);
        #1;
        chk_state("reset", 1'b0, 32'h0, 1'b0, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < n_vec; i++) begin
            chk_state($sformatf("vec%0d", i), tbl[i].exp_req, tbl[i].exp_addr,
                      tbl[i].exp_valid, tbl[i].exp_pc);
            r_ack_en      = tbl[i].ack_en;
            r_ready       = tbl[i].ready;
            r_redirect    = tbl[i].redir;
            r_redirect_pc = tbl[i].rpc;
            @(posedge clk);
            #1;
        end

        // Still in DISCARD here; reset must clear everything without a clock edge.
        chk_state("discard_hold", 1'b1, 32'h4, 1'b0, 32'h0);
        #2 rst_n = 1'b0;
        #1 chk_state("async_reset", 1'b0, 32'h0, 1'b0, 32'h0);
        r_ack_en = 1'b1; r_ready = 1'b1;
        @(posedge clk); #1;
        chk_state("reset_held", 1'b0, 32'h0, 1'b0, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_state("restart_e1", 1'b1, 32'h0, 1'b0, 32'h0);
        @(posedge clk); #1;
        chk_state("restart_e2", 1'b1, 32'h4, 1'b1, 32'h0);
        @(posedge clk); #1;
        chk_state("restart_e3", 1'b1, 32'h8, 1'b1, 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
